universal_shift_register: RTL and testbench



---
 rtl/usr_pkg.sv | 25 ++
 rtl/usr_shift_core.sv | 40 ++++
 rtl/universal_shift_register.sv | 133 +++++++++++++
 tb/tb_universal_shift_register.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Purpose: shared op codes and burst FSM states for the universal shift register.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package usr_pkg;

  // Operation codes; values match the 3-bit op field driven by callers.
  typedef enum logic [2:0] {
    USR_HOLD  = 3'd0,
    USR_SHL   = 3'd1,
    USR_SHR   = 3'd2,
    USR_ROL   = 3'd3,
    USR_ROR   = 3'd4,
    USR_ASR   = 3'd5,
    USR_LOAD  = 3'd6,
    USR_CLEAR = 3'd7
  } usr_op_e;

  // Burst engine states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } usr_state_e;

endpackage : usr_pkg

// File: rtl/usr_shift_core.sv
// Purpose: next-value function of the universal shift register for one operation.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle, the caller decides whether to commit.
//
// Ports:
//   op_i     operation to evaluate
//   dout_i   current register contents
//   sin_l_i  serial bit entering at the MSB (SHR)
//   sin_r_i  serial bit entering at the LSB (SHL)
//   pdin_i   parallel load data (LOAD)
//   next_o   value the register takes if op_i is applied
module usr_shift_core
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  usr_op_e          op_i,
  input  logic [WIDTH-1:0] dout_i,
  input  logic             sin_l_i,
  input  logic             sin_r_i,
  input  logic [WIDTH-1:0] pdin_i,
  output logic [WIDTH-1:0] next_o
);

  always_comb begin
    next_o = dout_i;
    case (op_i)
      USR_HOLD:  next_o = dout_i;
      USR_SHL:   next_o = {dout_i[WIDTH-2:0], sin_r_i};
      USR_SHR:   next_o = {sin_l_i, dout_i[WIDTH-1:1]};
      USR_ROL:   next_o = {dout_i[WIDTH-2:0], dout_i[WIDTH-1]};
      USR_ROR:   next_o = {dout_i[0], dout_i[WIDTH-1:1]};
      USR_ASR:   next_o = {dout_i[WIDTH-1], dout_i[WIDTH-1:1]};
      USR_LOAD:  next_o = pdin_i;
      USR_CLEAR: next_o = '0;
      default:   next_o = dout_i;
    endcase
  end

endmodule : usr_shift_core

// File: rtl/universal_shift_register.sv
// Purpose: WIDTH-bit universal shift register with single-step strobe and counted burst engine.
// Latency: single step visible after one edge; burst of N ends with done N+1 edges after start.
// Backpressure: start/en are only honoured in IDLE or DONE; requests while busy are dropped.
//
// Ports:
//   clock, rst      rising-edge clock, synchronous active-high reset
//   op, en          operation code and single-step strobe (used when not busy)
//   start, count    burst request and length (count=0 completes immediately)
//   sin_l, sin_r    serial inputs entering at MSB / LSB, sampled live
//   pdin            parallel load data, sampled live
//   dout            register contents; sout_l/sout_r are its MSB/LSB taps
//   busy, done      burst in progress / one-cycle completion pulse
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,  // must be >= 2
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] pdin,
  output logic [WIDTH-1:0] dout,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  usr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  usr_op_e          op_q, op_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  usr_op_e          op_live;
  usr_op_e          core_op;
  logic [WIDTH-1:0] core_next;
  logic             running;

  assign op_live = usr_op_e'(op);
  assign running = (state_q == RUN);

  // One shift core serves both paths: the latched op drives it during a
  // burst, the live op otherwise.
  assign core_op = running ? op_q : op_live;

  usr_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op_i    (core_op),
    .dout_i  (dout_q),
    .sin_l_i (sin_l),
    .sin_r_i (sin_r),
    .pdin_i  (pdin),
    .next_o  (core_next)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. DONE accepts requests exactly like IDLE so bursts can
  // run back to back without an idle gap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = (count != '0) ? RUN : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Datapath next-state: start has priority over en when not busy.
  always_comb begin
    dout_d = dout_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    if (running) begin
      dout_d = core_next;
      cnt_d  = cnt_q - CNT_W'(1);
    end else if (start) begin
      if (count != '0) begin
        op_d  = op_live;
        cnt_d = count;
      end
    end else if (en) begin
      dout_d = core_next;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      dout_q <= '0;
      cnt_q  <= '0;
      op_q   <= USR_HOLD;
    end else begin
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
    end
  end

  assign dout   = dout_q;
  assign sout_l = dout_q[WIDTH-1];
  assign sout_r = dout_q[0];

endmodule : universal_shift_register

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  localparam logic [2:0] OP_HOLD  = 3'd0;
  localparam logic [2:0] OP_SHL   = 3'd1;
  localparam logic [2:0] OP_SHR   = 3'd2;
  localparam logic [2:0] OP_ROL   = 3'd3;
  localparam logic [2:0] OP_ROR   = 3'd4;
  localparam logic [2:0] OP_ASR   = 3'd5;
  localparam logic [2:0] OP_LOAD  = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  logic             clock;
  logic             rst;
  logic [2:0]       op;
  logic             en;
  logic             start;
  logic [CNT_W-1:0] count;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] pdin;
  logic [WIDTH-1:0] dout;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;

  int checks;
  int failures;

  universal_shift_register #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock  (clock),
    .rst    (rst),
    .op     (op),
    .en     (en),
    .start  (start),
    .count  (count),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .pdin   (pdin),
    .dout   (dout),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .busy   (busy),
    .done   (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_state(input string name, input logic [WIDTH-1:0] exp_dout,
                             input logic exp_busy, input logic exp_done);
    checks++;
    if (dout !== exp_dout || busy !== exp_busy || done !== exp_done) begin
      failures++;
      $display("FAIL %s: dout=%h busy=%b done=%b, expected dout=%h busy=%b done=%b",
               name, dout, busy, done, exp_dout, exp_busy, exp_done);
    end
  endtask

  // Single step with en, then compare against the hand-computed result.
  task automatic single(input string name, input logic [2:0] o,
                        input logic [WIDTH-1:0] pd, input logic exp_l_in, input logic exp_r_in,
                        input logic [WIDTH-1:0] expected);
    op = o; pdin = pd; sin_l = exp_l_in; sin_r = exp_r_in; en = 1'b1;
    step();
    en = 1'b0;
    check_state(name, expected, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; op = OP_LOAD; en = 1'b1; start = 1'b1; count = 4'd5;
    sin_l = 1'b1; sin_r = 1'b1; pdin = 8'hFF;
    step();
    step();
    check_state("reset", 8'h00, 1'b0, 1'b0);
    checks++;
    if (sout_l !== 1'b0 || sout_r !== 1'b0) begin
      failures++;
      $display("FAIL reset_taps: sout_l=%b sout_r=%b, expected 0 0", sout_l, sout_r);
    end
    rst = 1'b0; en = 1'b0; start = 1'b0; count = '0;
    step();
    check_state("post_reset_idle", 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_single_step();
    single("load_a5", OP_LOAD, 8'hA5, 1'b0, 1'b0, 8'hA5);
    checks++;
    if (sout_l !== 1'b1 || sout_r !== 1'b1) begin
      failures++;
      $display("FAIL taps_a5: sout_l=%b sout_r=%b, expected 1 1", sout_l, sout_r);
    end
    single("shl_sin_r1", OP_SHL, 8'h00, 1'b0, 1'b1, 8'h4B);
    single("shr_sin_l0", OP_SHR, 8'h00, 1'b0, 1'b1, 8'h25);
    single("hold", OP_HOLD, 8'hFF, 1'b1, 1'b1, 8'h25);
    // en low: nothing happens even with a destructive op.
    op = OP_CLEAR; en = 1'b0;
    step();
    check_state("en_low_no_change", 8'h25, 1'b0, 1'b0);
    single("load_81_a", OP_LOAD, 8'h81, 1'b0, 1'b0, 8'h81);
    single("rol_81", OP_ROL, 8'h00, 1'b0, 1'b0, 8'h03);
    single("load_81_b", OP_LOAD, 8'h81, 1'b0, 1'b0, 8'h81);
    single("ror_81", OP_ROR, 8'h00, 1'b0, 1'b0, 8'hC0);
    single("load_80", OP_LOAD, 8'h80, 1'b0, 1'b0, 8'h80);
    single("asr_80", OP_ASR, 8'h00, 1'b0, 1'b0, 8'hC0);
    checks++;
    if (sout_l !== 1'b1 || sout_r !== 1'b0) begin
      failures++;
      $display("FAIL taps_c0: sout_l=%b sout_r=%b, expected 1 0", sout_l, sout_r);
    end
    single("shr_sin_l1", OP_SHR, 8'h00, 1'b1, 1'b0, 8'hE0);
    single("clear", OP_CLEAR, 8'hFF, 1'b1, 1'b1, 8'h00);
  endtask

  task automatic test_burst();
    single("burst_preload", OP_LOAD, 8'h01, 1'b0, 1'b0, 8'h01);
    op = OP_ROL; count = 4'd3; start = 1'b1;
    step();                                  // edge 0
    start = 1'b0; count = '0;
    op = OP_CLEAR; en = 1'b1;                // must be ignored while busy
    check_state("burst_accept", 8'h01, 1'b1, 1'b0);
    step();
    check_state("burst_1", 8'h02, 1'b1, 1'b0);
    step();
    check_state("burst_2", 8'h04, 1'b1, 1'b0);
    step();
    check_state("burst_3_done", 8'h08, 1'b0, 1'b1);
    en = 1'b0; op = OP_HOLD;
    step();
    check_state("burst_after_done", 8'h08, 1'b0, 1'b0);
  endtask

  task automatic test_zero_count();
    op = OP_ROL; count = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    check_state("zero_count_done", 8'h08, 1'b0, 1'b1);
    step();
    check_state("zero_count_idle", 8'h08, 1'b0, 1'b0);
    // start and en together: start wins, so the CLEAR step is not applied.
    op = OP_CLEAR; count = 4'd0; start = 1'b1; en = 1'b1;
    step();
    start = 1'b0; en = 1'b0; op = OP_HOLD;
    check_state("start_beats_en", 8'h08, 1'b0, 1'b1);
    step();
    check_state("start_beats_en_idle", 8'h08, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    single("mid_preload", OP_LOAD, 8'h80, 1'b0, 1'b0, 8'h80);
    op = OP_SHR; count = 4'd7; start = 1'b1; sin_l = 1'b0;
    step();
    start = 1'b0;
    step();
    check_state("mid_shift_1", 8'h40, 1'b1, 1'b0);
    step();
    step();
    check_state("mid_shift_3", 8'h10, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_state("mid_reset", 8'h00, 1'b0, 1'b0);
    step();
    check_state("mid_no_done", 8'h00, 1'b0, 1'b0);
    single("mid_step_after", OP_LOAD, 8'h3C, 1'b0, 1'b0, 8'h3C);
  endtask

  task automatic test_back_to_back();
    op = OP_SHL; count = 4'd2; start = 1'b1; sin_r = 1'b1;
    step();
    start = 1'b0;
    op = OP_CLEAR;                           // latched op must be used
    step();
    check_state("b2b_first_1", 8'h79, 1'b1, 1'b0);
    step();
    check_state("b2b_first_done", 8'hF3, 1'b0, 1'b1);
    op = OP_ROR; count = 4'd2; start = 1'b1;
    step();
    start = 1'b0; op = OP_HOLD;
    check_state("b2b_second_accept", 8'hF3, 1'b1, 1'b0);
    step();
    check_state("b2b_second_1", 8'hF9, 1'b1, 1'b0);
    step();
    check_state("b2b_second_done", 8'hFC, 1'b0, 1'b1);
    step();
    check_state("b2b_idle", 8'hFC, 1'b0, 1'b0);
  endtask

  task automatic test_max_count();
    int busy_cycles;
    bit seen_done;
    single("max_preload", OP_LOAD, 8'h01, 1'b0, 1'b0, 8'h01);
    op = OP_ROL; count = 4'd15; start = 1'b1;
    step();
    start = 1'b0; count = '0;
    busy_cycles = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 40 && !seen_done; i++) begin
      if (busy) busy_cycles++;
      if (done) seen_done = 1'b1;
      else step();
    end
    checks++;
    if (!seen_done) begin
      failures++;
      $display("FAIL max_timeout: done not seen within 40 cycles, busy_cycles=%0d", busy_cycles);
    end
    checks++;
    if (busy_cycles != 15) begin
      failures++;
      $display("FAIL max_busy_len: busy_cycles=%0d, expected 15", busy_cycles);
    end
    // 15 left rotations of 8 bits equal 7, moving bit 0 to bit 7.
    check_state("max_result", 8'h80, 1'b0, seen_done);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL max_done: done=%b, expected 1", done);
    end
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; op = OP_HOLD; en = 1'b0; start = 1'b0; count = '0;
    sin_l = 1'b0; sin_r = 1'b0; pdin = '0;
    test_reset();
    test_single_step();
    test_burst();
    test_zero_count();
    test_reset_mid_burst();
    test_back_to_back();
    test_max_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_universal_shift_register
